// File: rtl/dx_stage_pkg.sv
// Shared definitions for the decode/execute pipeline register stage.
package dx_stage_pkg;

  // Stall FSM encoding; 2'd3 is unused and recovers to ST_RUN.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_HOLD = 2'd2
  } dx_state_e;

  // Control bundle carried through the D/X register.
  typedef struct packed {
    logic valid;
    logic regwrite;
    logic r15write;
    logic memread;
    logic branch;
  } dx_ctrl_t;

  localparam dx_ctrl_t   CTRL_BUBBLE = '0;
  localparam logic [3:0] REG_ZERO    = 4'd0;
  localparam logic [7:0] CNT_MAX     = 8'hFF;

  // Saturating increment for the bubble counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dx_stage_if.sv
// Decode-side inputs and D/X-side outputs of the dx_stage block.
interface dx_stage_if;
  logic [3:0] f_dop1;
  logic [3:0] f_dop2;
  logic       dec_valid;
  logic       dec_regwrite;
  logic       dec_r15write;
  logic       dec_memread;
  logic       dec_branch;
  logic       x_flush;
  logic       mem_busy;

  logic [3:0] d_xop1;
  logic [3:0] d_xop2;
  logic       d_xvalid;
  logic       d_xregwrite;
  logic       d_xr15write;
  logic       d_xmemread;
  logic       d_xbranch;
  logic       stall_fd;
  logic [7:0] bubble_cnt;
  logic [1:0] state;

  // Master drives decode/control, slave (the stage) drives D/X outputs.
  modport master (
    output f_dop1, f_dop2, dec_valid, dec_regwrite, dec_r15write,
           dec_memread, dec_branch, x_flush, mem_busy,
    input  d_xop1, d_xop2, d_xvalid, d_xregwrite, d_xr15write,
           d_xmemread, d_xbranch, stall_fd, bubble_cnt, state
  );

  modport slave (
    input  f_dop1, f_dop2, dec_valid, dec_regwrite, dec_r15write,
           dec_memread, dec_branch, x_flush, mem_busy,
    output d_xop1, d_xop2, d_xvalid, d_xregwrite, d_xr15write,
           d_xmemread, d_xbranch, stall_fd, bubble_cnt, state
  );
endinterface

// File: rtl/dx_hazard_detect.sv
// Combinational load-use detector: a valid load in D/X whose destination
// (op2, never r0) is read by the valid instruction sitting in decode.
module dx_hazard_detect
  import dx_stage_pkg::*;
(
  input  logic       dx_valid,
  input  logic       dx_memread,
  input  logic [3:0] dx_op2,
  input  logic [3:0] f_dop1,
  input  logic [3:0] f_dop2,
  input  logic       dec_valid,
  output logic       load_use
);

  // A bubble has dx_valid=0, so it can never raise a hazard.
  assign load_use = dx_valid & dx_memread & (dx_op2 != REG_ZERO) &
                    ((dx_op2 == f_dop1) | (dx_op2 == f_dop2)) & dec_valid;

endmodule

// File: rtl/dx_stage.sv
// D/X pipeline register with load-use stall FSM, memory freeze,
// branch flush and a saturating bubble counter.
module dx_stage
  import dx_stage_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  dx_stage_if.slave dx
);

  dx_state_e  state_q, state_d;
  dx_ctrl_t   ctrl_q, ctrl_d;
  logic [3:0] op1_q, op1_d;
  logic [3:0] op2_q, op2_d;
  logic [7:0] cnt_q, cnt_d;
  logic       stall_c;
  logic       load_use;
  logic       lu_take;

  dx_hazard_detect u_haz (
    .dx_valid   (ctrl_q.valid),
    .dx_memread (ctrl_q.memread),
    .dx_op2     (op2_q),
    .f_dop1     (dx.f_dop1),
    .f_dop2     (dx.f_dop2),
    .dec_valid  (dx.dec_valid),
    .load_use   (load_use)
  );

  // The stall cycle itself never re-stalls the instruction it held.
  assign lu_take = load_use & (state_q != ST_LU_STALL);

  // Next-state and D/X capture, priority flush > mem_busy > load-use > advance.
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    if (dx.x_flush) begin
      ctrl_d  = CTRL_BUBBLE;
      op1_d   = REG_ZERO;
      op2_d   = REG_ZERO;
      state_d = ST_RUN;
    end else if (dx.mem_busy) begin
      stall_c = 1'b1;
      state_d = ST_MEM_HOLD;
    end else if (lu_take) begin
      stall_c = 1'b1;
      ctrl_d  = CTRL_BUBBLE;
      op1_d   = REG_ZERO;
      op2_d   = REG_ZERO;
      cnt_d   = sat_inc(cnt_q);
      state_d = ST_LU_STALL;
    end else begin
      state_d = ST_RUN;
      if (dx.dec_valid) begin
        ctrl_d = '{valid:    1'b1,
                   regwrite: dx.dec_regwrite,
                   r15write: dx.dec_r15write,
                   memread:  dx.dec_memread,
                   branch:   dx.dec_branch};
        op1_d  = dx.f_dop1;
        op2_d  = dx.f_dop2;
      end else begin
        ctrl_d = CTRL_BUBBLE;
        op1_d  = REG_ZERO;
        op2_d  = REG_ZERO;
      end
    end
    // Unused encoding always recovers to RUN on the next edge.
    if (!(state_q inside {ST_RUN, ST_LU_STALL, ST_MEM_HOLD}))
      state_d = ST_RUN;
  end

  // State, D/X register and counter update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      ctrl_q  <= CTRL_BUBBLE;
      op1_q   <= REG_ZERO;
      op2_q   <= REG_ZERO;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dx.d_xop1      = op1_q;
  assign dx.d_xop2      = op2_q;
  assign dx.d_xvalid    = ctrl_q.valid;
  assign dx.d_xregwrite = ctrl_q.regwrite;
  assign dx.d_xr15write = ctrl_q.r15write;
  assign dx.d_xmemread  = ctrl_q.memread;
  assign dx.d_xbranch   = ctrl_q.branch;
  assign dx.stall_fd    = stall_c & ~rst;
  assign dx.bubble_cnt  = cnt_q;
  assign dx.state       = state_q;

endmodule

// File: tb/tb_dx_stage.sv
// Directed bench for dx_stage with a cycle model and per-cycle compare.
module tb_dx_stage;

  logic clk = 1'b0;
  logic rst;
  dx_stage_if dif();

  dx_stage dut (.clk(clk), .rst(rst), .dx(dif));

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Behavioural model: what D/X, state and counter must hold.
  bit         m_init = 0;
  logic [4:0] m_ctrl;   // {valid, regwrite, r15write, memread, branch}
  int         m_op1, m_op2, m_cnt, m_state;
  bit         m_opdef;

  function automatic bit m_haz();
    return m_ctrl[4] && m_ctrl[1] && m_op2 != 0 &&
           (m_op2 == int'(dif.f_dop1) || m_op2 == int'(dif.f_dop2)) && dif.dec_valid;
  endfunction

  function automatic bit m_stall();
    if (rst || dif.x_flush) return 0;
    if (dif.mem_busy) return 1;
    return m_haz() && m_state != 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1; m_ctrl = '0; m_op1 = 0; m_op2 = 0; m_opdef = 1; m_cnt = 0; m_state = 0;
    end else if (m_init) begin
      if (dif.x_flush) begin
        m_ctrl = '0; m_op1 = 0; m_op2 = 0; m_opdef = 1; m_state = 0;
      end else if (dif.mem_busy) begin
        m_state = 2;
      end else if (m_haz() && m_state != 1) begin
        m_ctrl = '0; m_op1 = 0; m_op2 = 0; m_opdef = 1; m_state = 1;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end else begin
        m_state = 0;
        m_opdef = dif.dec_valid;
        if (dif.dec_valid) begin
          m_ctrl = {1'b1, dif.dec_regwrite, dif.dec_r15write, dif.dec_memread, dif.dec_branch};
          m_op1 = dif.f_dop1; m_op2 = dif.f_dop2;
        end else begin
          m_ctrl = '0;
        end
      end
    end
  end

  // Compare every cycle once the model has seen reset.
  always @(negedge clk) begin
    if (m_init) begin
      chk("stall_fd", dif.stall_fd, m_stall());
      chk("ctrl", {dif.d_xvalid, dif.d_xregwrite, dif.d_xr15write, dif.d_xmemread, dif.d_xbranch}, m_ctrl);
      chk("state", dif.state, m_state);
      chk("bubble_cnt", dif.bubble_cnt, m_cnt);
      if (m_opdef) begin
        chk("op1", dif.d_xop1, m_op1);
        chk("op2", dif.d_xop2, m_op2);
      end
    end
  end

  task automatic dec(input int o1, input int o2, input bit v, input bit rw,
                     input bit r15, input bit mr, input bit br);
    dif.f_dop1 = o1[3:0]; dif.f_dop2 = o2[3:0];
    dif.dec_valid = v; dif.dec_regwrite = rw; dif.dec_r15write = r15;
    dif.dec_memread = mr; dif.dec_branch = br;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; dif.x_flush = 0; dif.mem_busy = 0;
    dec(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_state", dif.state, 0);
    chk("rst_cnt", dif.bubble_cnt, 0);
    chk("rst_valid", dif.d_xvalid, 0);
    chk("rst_stall", dif.stall_fd, 0);
    rst = 0;

    // Load-use: LDR r3 then consumer reading r3
    dec(1, 3, 1, 1, 0, 1, 0); tick();
    dec(3, 5, 1, 1, 0, 0, 0); #2 chk("lu_stall", dif.stall_fd, 1); tick();
    chk("lu_bubble", dif.d_xvalid, 0);
    chk("lu_state", dif.state, 1);
    chk("lu_cnt", dif.bubble_cnt, 1);
    #2 chk("lu_release", dif.stall_fd, 0); tick();
    chk("lu_consumer_v", dif.d_xvalid, 1);
    chk("lu_consumer_op1", dif.d_xop1, 3);
    chk("lu_state_run", dif.state, 0);

    // r0 is never a hazard
    dec(2, 0, 1, 1, 0, 1, 0); tick();
    dec(0, 0, 1, 1, 0, 0, 0); #2 chk("r0_stall", dif.stall_fd, 0); tick();
    chk("r0_cnt", dif.bubble_cnt, 1);
    chk("r0_valid", dif.d_xvalid, 1);

    // Flush beats load-use
    dec(1, 4, 1, 1, 0, 1, 0); tick();
    dec(4, 1, 1, 1, 0, 0, 0); dif.x_flush = 1;
    #2 chk("fl_stall", dif.stall_fd, 0); tick();
    dif.x_flush = 0;
    chk("fl_valid", dif.d_xvalid, 0);
    chk("fl_state", dif.state, 0);
    chk("fl_cnt", dif.bubble_cnt, 1);

    // Memory freeze with pending hazard
    dec(1, 6, 1, 1, 0, 1, 0); tick();
    dec(6, 2, 1, 1, 1, 0, 1); dif.mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #2 chk("mb_stall", dif.stall_fd, 1); tick();
      chk("mb_state", dif.state, 2);
      chk("mb_op2", dif.d_xop2, 6);
      chk("mb_memread", dif.d_xmemread, 1);
    end
    dif.mem_busy = 0;
    #2 chk("mb_lu_stall", dif.stall_fd, 1); tick();
    chk("mb_lu_state", dif.state, 1);
    chk("mb_lu_cnt", dif.bubble_cnt, 2);
    tick();
    chk("mb_consumer_op1", dif.d_xop1, 6);
    chk("mb_consumer_r15", dif.d_xr15write, 1);
    chk("mb_consumer_br", dif.d_xbranch, 1);

    // dec_valid=0 advances as a bubble
    dec(9, 9, 0, 1, 1, 1, 1); tick();
    chk("inv_valid", dif.d_xvalid, 0);
    chk("inv_rw", dif.d_xregwrite, 0);
    chk("inv_cnt", dif.bubble_cnt, 2);

    // r15write with op2=0
    dec(0, 0, 1, 0, 1, 0, 0); tick();
    chk("r15_op0", dif.d_xr15write, 1);

    // Saturation
    for (int i = 0; i < 300; i++) begin
      dec(1, 7, 1, 1, 0, 1, 0); tick();
      dec(7, 7, 1, 1, 0, 0, 0); tick(); tick();
    end
    chk("sat_cnt", dif.bubble_cnt, 255);

    // Reset while hazard pending: stall forced low
    dec(1, 8, 1, 1, 0, 1, 0); tick();
    dec(8, 1, 1, 1, 0, 0, 0); rst = 1;
    #2 chk("rst_force_stall", dif.stall_fd, 0); tick();
    chk("rst2_state", dif.state, 0);
    chk("rst2_cnt", dif.bubble_cnt, 0);
    chk("rst2_op1", dif.d_xop1, 0);
    rst = 0; tick();
    chk("rst2_adv_v", dif.d_xvalid, 1);
    chk("rst2_adv_op1", dif.d_xop1, 8);

    // Reset during LU_STALL
    dec(1, 8, 1, 1, 0, 1, 0); tick();
    dec(8, 1, 1, 1, 0, 0, 0); tick();
    chk("rst3_in_stall", dif.state, 1);
    rst = 1; tick(); rst = 0;
    chk("rst3_state", dif.state, 0);
    chk("rst3_cnt", dif.bubble_cnt, 0);
    chk("rst3_valid", dif.d_xvalid, 0);
    #2 chk("rst3_stall", dif.stall_fd, 0); tick();
    chk("rst3_adv_v", dif.d_xvalid, 1);
    chk("rst3_adv_op1", dif.d_xop1, 8);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
